// File: rtl/mod_count_pkg.sv
// Shared types and constants for the modulo-N count controller.
// MOD_COUNT_DEBOUNCE_EN (in btn_edge) enables the button debouncer that uses DEBOUNCE_CYC.
package mod_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int DEBOUNCE_CYC = 16;
  localparam int DB_W         = 5;

  localparam int START   = 0;
  localparam int STOP    = 1;
  localparam int STEP    = 2;
  localparam int CLEAR   = 3;
  localparam int NUM_BTN = 4;

endpackage

// File: rtl/mod_count_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchroniser, optional debouncer, rising-edge detector.
// Debouncer present only when MOD_COUNT_DEBOUNCE_EN is defined.
module btn_edge
  import mod_count_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;
  logic level;

  // Reset to the "pressed" level so a button held through reset release never
  // looks like a fresh press; a real edge needs the button to be seen low first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef MOD_COUNT_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYC - 1);

  logic            stable_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b1;
      db_cnt_q <= DB_LOAD;
    end else if (sync2_q == stable_q) begin
      db_cnt_q <= DB_LOAD;
    end else if (db_cnt_q == '0) begin
      stable_q <= sync2_q;
      db_cnt_q <= DB_LOAD;
    end else begin
      db_cnt_q <= db_cnt_q - 1'b1;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= level;
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/mod_count_ctrl.sv
// Button-driven FSM sequencing a prescaled modulo-N counter with wrap pulse/toggle.
// MOD_COUNT_DEBOUNCE_EN adds a debouncer inside each btn_edge instance.
module mod_count_ctrl
  import mod_count_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 4,
  parameter int PS_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_step,
  input  logic             btn_clear,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_pulse,
  output logic             wrap_toggle,
  output logic             running,
  output logic             paused
);

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE  = 1;
  localparam logic [WIDTH-1:0] CNT_ONE = 1;

  logic [NUM_BTN-1:0] btn_lvl, btn_ev;

  assign btn_lvl[START] = btn_start;
  assign btn_lvl[STOP]  = btn_stop;
  assign btn_lvl[STEP]  = btn_step;
  assign btn_lvl[CLEAR] = btn_clear;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_edge u_btn_edge (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_lvl[i]),
      .rise_o (btn_ev[i])
    );
  end

  state_e           state_q;
  logic [WIDTH-1:0] count_q, mod_q;
  logic [PS_W-1:0]  ps_q;
  logic             wrap_pulse_q, wrap_toggle_q;

  logic             tick;
  logic             wrap_d;
  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] count_d;

  // mod_q==0 gives mod_m1 == all-ones, i.e. the natural full-range wrap.
  always_comb begin
    tick    = 1'b0;
    mod_m1  = mod_q - CNT_ONE;
    wrap_d  = (count_q == mod_m1);
    count_d = wrap_d ? '0 : count_q + CNT_ONE;
    case (state_q)
      RUN:     tick = !btn_ev[STOP] && (ps_q == PS_LAST);
      PAUSE:   tick = !btn_ev[STOP] && !btn_ev[START] && btn_ev[STEP];
      default: tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      mod_q         <= '0;
      ps_q          <= '0;
      wrap_pulse_q  <= 1'b0;
      wrap_toggle_q <= 1'b0;
    end else begin
      wrap_pulse_q <= 1'b0;
      if (btn_ev[CLEAR]) begin
        state_q <= IDLE;
        count_q <= '0;
        ps_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!btn_ev[STOP] && btn_ev[START]) begin
              state_q <= RUN;
              mod_q   <= mod_val;
              ps_q    <= '0;
            end
          end
          RUN: begin
            if (btn_ev[STOP]) state_q <= PAUSE;
            else              ps_q    <= (ps_q == PS_LAST) ? '0 : ps_q + PS_ONE;
          end
          PAUSE: begin
            if (!btn_ev[STOP] && btn_ev[START]) state_q <= RUN;
          end
          default: state_q <= IDLE;
        endcase
        if (tick) begin
          count_q <= count_d;
          if (wrap_d) begin
            wrap_pulse_q  <= 1'b1;
            wrap_toggle_q <= ~wrap_toggle_q;
          end
        end
      end
    end
  end

  assign count       = count_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign wrap_toggle = wrap_toggle_q;
  assign running     = (state_q == RUN);
  assign paused      = (state_q == PAUSE);

endmodule
